pitcher_scheduler: RTL and testbench

//  Shares one blockpitcher instance between N_REQ requesters on the 50 MHz clock domain.

---
 rtl/pitcher_pkg.sv | 25 ++
 rtl/pitcher_scheduler_if.sv | 31 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/pitcher_scheduler.sv | 116 +++++++++++
 tb/tb_pitcher_scheduler.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pitcher_pkg.sv
// pitcher_pkg: shared types and default constants for the pitcher scheduler.
//   state_t       scheduler FSM states
//   CLK_HZ        system clock frequency
//   *_DEF         default parameter values for pitcher_scheduler
//   cnt_width()   width of a counter that must hold 0..max_val (min 1 bit)
package pitcher_pkg;

    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned TIMEOUT_CYC_DEF = 4 * CLK_HZ;
    localparam int unsigned GAP_CYC_DEF     = 50;
    localparam int unsigned N_REQ_DEF       = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ASK,
        WAIT,
        GAP
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pitcher_scheduler_if.sv
// pitcher_scheduler_if: requester and pitcher signals of the scheduler.
//   req          requester level requests (held until ack/tout)
//   ack / tout   one-hot completion / timeout pulses back to the requesters
//   res          result bit of the last completed transaction
//   busy         scheduler occupied (grant through gap)
//   ask          single-cycle start pulse to the pitcher
//   pitch_done   single-cycle completion pulse from the pitcher
//   pitch_result pitcher result bit, valid with pitch_done
// master: requester/pitcher side; slave: scheduler side.
interface pitcher_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] tout;
    logic             res;
    logic             busy;
    logic             ask;
    logic             pitch_done;
    logic             pitch_result;

    modport master (
        output req, pitch_done, pitch_result,
        input  ack, tout, res, busy, ask
    );

    modport slave (
        input  req, pitch_done, pitch_result,
        output ack, tout, res, busy, ask
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   i_req  request vector
//   i_ptr  highest-priority requester index this round
//   o_gnt  one-hot grant (all zero when no request)
//   o_idx  index of the granted requester
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [31:0] w_dist;
    logic [31:0] w_best;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        w_dist = '0;
        w_best = N;
        for (int unsigned j = 0; j < N; j++) begin
            // upward distance from the pointer with wrap; nearest requester wins
            w_dist = (j + N - 32'(i_ptr)) % N;
            if (i_req[IW'(j)] && (w_dist < w_best)) begin
                w_best        = w_dist;
                o_gnt         = '0;
                o_gnt[IW'(j)] = 1'b1;
                o_idx         = IW'(j);
            end
        end
    end
endmodule

// File: rtl/pitcher_scheduler.sv
// pitcher_scheduler: shares one blockpitcher between N_REQ requesters.
// Round-robin grant, single-cycle ask, waits for pitch_done (or timeout),
// returns the result to the winner, then forces an idle gap.
//   clk    system clock
//   rst_n  asynchronous active-low reset (release synchronised internally)
//   bus    pitcher_scheduler_if.slave: req/ack/tout/res/busy/ask/pitch_done/pitch_result
module pitcher_scheduler
    import pitcher_pkg::*;
#(
    parameter int unsigned N_REQ       = N_REQ_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned GAP_CYC     = GAP_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pitcher_scheduler_if.slave bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = cnt_width(TIMEOUT_CYC);
    localparam int unsigned GW = cnt_width(GAP_CYC);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]    w_gnt_idx;
    logic [N_REQ-1:0] r_sel;
    logic [IW-1:0]    r_ptr;
    logic [TW-1:0]    r_to_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [N_REQ-1:0] r_ack;
    logic [N_REQ-1:0] r_tout;
    logic             r_res;
    logic             w_done;
    logic             w_timeout;

    // Every assertion clears both stages, so a bouncing release restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE:  if (|w_gnt) w_state_nxt = GRANT;
            GRANT: w_state_nxt = ASK;
            ASK:   w_state_nxt = WAIT;
            WAIT: begin
                // pitch_done takes priority over a timeout on the same cycle
                if (bus.pitch_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = GAP;
                end else if ((TIMEOUT_CYC != 0) && (r_to_cnt >= TO_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                if ((GAP_CYC == 0) || (r_gap_cnt >= GAP_LAST)) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sel     <= '0;
            r_ptr     <= '0;
            r_to_cnt  <= '0;
            r_gap_cnt <= '0;
            r_ack     <= '0;
            r_tout    <= '0;
            r_res     <= 1'b0;
        end else begin
            r_ack  <= w_done    ? r_sel : '0;
            r_tout <= w_timeout ? r_sel : '0;
            if (w_done) r_res <= bus.pitch_result;
            if ((r_state == IDLE) && (|w_gnt)) begin
                r_sel <= w_gnt;
                r_ptr <= (32'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end
            // Cleared on the GRANT->ASK edge so the ask cycle counts as 0:
            // the timeout pulse then lands exactly TIMEOUT_CYC cycles after ask.
            if (r_state == GRANT)      r_to_cnt <= '0;
            else if (r_to_cnt != '1)   r_to_cnt <= r_to_cnt + 1'b1;
            if (r_state == WAIT)       r_gap_cnt <= '0;
            else if (r_gap_cnt != '1)  r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    assign bus.ask  = (r_state == ASK);
    assign bus.busy = (r_state != IDLE);
    assign bus.ack  = r_ack;
    assign bus.tout = r_tout;
    assign bus.res  = r_res;

endmodule

// File: tb/tb_pitcher_scheduler.sv
module tb_pitcher_scheduler;
    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int TOUT = 1000;
    localparam int GAPC = 50;

    typedef struct {
        logic [N-1:0] add;
        int           delay;   // 0: pitcher never answers
        logic         result;
        int           exp_w;
        logic         exp_to;
        logic         exp_res;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [N-1:0] m_pending;
    int           m_ptr;
    logic         m_res;

    pitcher_scheduler_if #(.N_REQ(N)) bus ();

    pitcher_scheduler #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TOUT),
        .GAP_CYC     (GAPC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first pending requester at or after the pointer, with wrap.
    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++)
            if (p[IW'((ptr + k) % N)]) return (ptr + k) % N;
        return -1;
    endfunction

    // Called at a negedge with bus.req already set and the DUT idle.
    task automatic txn(input int lat, input int exp_w, input int delay, input logic result,
                       input logic exp_to, input logic exp_res, input logic drop_early);
        logic [N-1:0] onehot;
        int k, i, j, e, asks, exp_e;
        logic seen, idle;
        onehot = N'(1) << exp_w;
        k = 0; seen = 1'b0;
        while (!seen && k < lat + 8) begin
            @(negedge clk); k++;
            if (bus.ask) seen = 1'b1;
            else chk("busy_before_ask", 32'(bus.busy), 32'(k >= lat - 1));
            chk("no_pulse_before_ask", 32'({bus.ack, bus.tout}), 32'(0));
        end
        chk("ask_latency", seen ? k : 0, lat);

        exp_e = exp_to ? TOUT : delay + 1;
        i = 0; e = 0; asks = 0;
        while (e == 0 && i < TOUT + 20) begin
            @(negedge clk); i++;
            if (bus.ask) asks++;
            if (bus.ack != '0 || bus.tout != '0) begin
                e = i;
                chk("ack_vec",  32'(bus.ack),  exp_to ? 32'(0) : 32'(onehot));
                chk("tout_vec", 32'(bus.tout), exp_to ? 32'(onehot) : 32'(0));
                chk("res",      32'(bus.res),  32'(exp_res));
                chk("busy_at_done", 32'(bus.busy), 32'(1));
                bus.req = bus.req & ~onehot;
            end
            if (drop_early && i == 1) bus.req = bus.req & ~onehot;
            bus.pitch_done   = (i == delay);
            bus.pitch_result = (i == delay) ? result : 1'($urandom_range(0, 1));
        end
        chk("done_time", e, exp_e);

        j = 0; idle = 1'b0;
        while (!idle && j < GAPC + 8) begin
            @(negedge clk); j++;
            bus.pitch_done = 1'b0;
            if (bus.ask) asks++;
            if (j == 1) chk("pulse_width", 32'({bus.ack, bus.tout}), 32'(0));
            if (!bus.busy) idle = 1'b1;
        end
        chk("gap_len", j, GAPC);
        chk("ask_single", asks, 0);
        chk("res_held", 32'(bus.res), 32'(exp_res));

        m_pending = m_pending & ~onehot;
        m_ptr     = (exp_w + 1) % N;
        m_res     = exp_res;
    endtask

    vec_t vecs[10];

    initial begin
        int k;
        logic seen;
        checks = 0; errors = 0;
        vecs[0] = '{4'b1111,   10, 1'b1, 0, 1'b0, 1'b1};
        vecs[1] = '{4'b0000,   10, 1'b0, 1, 1'b0, 1'b0};
        vecs[2] = '{4'b0000,   10, 1'b1, 2, 1'b0, 1'b1};
        vecs[3] = '{4'b0001,   10, 1'b0, 3, 1'b0, 1'b0};
        vecs[4] = '{4'b0000,   10, 1'b1, 0, 1'b0, 1'b1};
        vecs[5] = '{4'b0001,  100, 1'b1, 0, 1'b0, 1'b1};
        vecs[6] = '{4'b0110,    0, 1'b0, 1, 1'b1, 1'b1};
        vecs[7] = '{4'b0000,   10, 1'b0, 2, 1'b0, 1'b0};
        vecs[8] = '{4'b1000,  999, 1'b1, 3, 1'b0, 1'b1};
        vecs[9] = '{4'b0001, 1000, 1'b0, 0, 1'b1, 1'b1};

        rst_n = 1'b0;
        bus.req = '0; bus.pitch_done = 1'b0; bus.pitch_result = 1'b0;
        m_pending = '0; m_ptr = 0; m_res = 1'b0;

        // Bounced reset release, then a request: the first clean window must be 2 cycles.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.ack, bus.tout, bus.ask, bus.busy, bus.res}), 32'(0));
        #5  rst_n = 1'b1;
        #10 rst_n = 1'b0;
        #19 chk("bounce_outputs", 32'({bus.ack, bus.tout, bus.ask, bus.busy, bus.res}), 32'(0));
        #1  rst_n = 1'b1;
        @(negedge clk);
        m_pending = 4'b1000; bus.req = m_pending;
        txn(4, 3, 20, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed table: round-robin order, long latency, timeout boundaries.
        foreach (vecs[v]) begin
            m_pending = m_pending | vecs[v].add;
            bus.req = m_pending;
            txn(2, vecs[v].exp_w, vecs[v].delay, vecs[v].result,
                vecs[v].exp_to, vecs[v].exp_res, 1'b0);
        end

        // pitch_done while idle must not disturb anything.
        bus.pitch_done = 1'b1; bus.pitch_result = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); bus.pitch_done = 1'b0;
            chk("idle_done_quiet", 32'({bus.ack, bus.tout, bus.ask, bus.busy, bus.res}), 32'(m_res));
        end

        // Reset during WAIT: abort silently, pointer back to requester 0.
        m_pending = 4'b0011; bus.req = m_pending;
        k = 0; seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk); k++;
            if (bus.ask) seen = 1'b1;
        end
        chk("abort_ask_latency", seen ? k : 0, 2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("abort_async", 32'({bus.ask, bus.busy}), 32'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({bus.ack, bus.tout, bus.ask, bus.busy, bus.res}), 32'(0));
        end
        rst_n = 1'b1;
        m_ptr = 0; m_res = 1'b0;
        txn(4, 0, 5, 1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized traffic against the transaction-level model.
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] add, drop, p;
            int delay, w;
            logic result, to, dropx;
            add  = N'($urandom_range(0, 15));
            drop = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            p = (m_pending | add) & ~drop;
            if (p == '0) p = N'(1) << $urandom_range(0, N - 1);
            m_pending = p;
            delay  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
            result = 1'($urandom_range(0, 1));
            dropx  = 1'($urandom_range(0, 1));
            w  = rr_pick(m_pending, m_ptr);
            to = (delay == 0) || (delay >= TOUT);
            bus.req = m_pending;
            txn(2, w, delay, result, to, to ? m_res : result, dropx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
